goldilocks_mod_reduct: RTL and testbench

GOLDILOCKS_MOD_REDUCT -- requirements
Module: goldilocks_mod_reduct

---
 rtl/goldilocks_mod_reduct.sv | 159 +++++++++++++++
 tb/tb_goldilocks_mod_reduct.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goldilocks_mod_reduct.sv
// ---------------------------------------------------------------------------
// goldilocks_mod_reduct
//
// Reduces a 2*MOD_W-bit operand x modulo p = 2^MOD_W - 2^(MOD_W/2) + 1 in a
// short valid/ready pipeline. It uses the identities 2^MOD_W = 2^H - 1 and
// 2^(MOD_W+H) = -1 (mod p), with H = MOD_W/2.
//
// Parameters
//   MOD_W   modulus width (even, 8..64)
//   SIDE_W  sideband width carried alongside each operand
//
// Ports
//   clk       rising-edge clock
//   s_rst_n   asynchronous active-low reset; clears the valid bits only
//   in_data   operand x (2*MOD_W bits)
//   in_side   sideband travelling with the operand
//   in_vld    operand valid
//   in_rdy    operand accepted when in_vld & in_rdy
//   out_data  x mod p, fully reduced
//   out_side  sideband of the same operand
//   out_vld   result valid
//   out_rdy   result consumed when out_vld & out_rdy
//
// Build option
//   GOLDILOCKS_MOD_REDUCT_OUT_REG_EN  adds a fourth register stage after the
//   final reduction (latency 4 instead of 3, same handshake rules).
// ---------------------------------------------------------------------------
module goldilocks_mod_reduct #(
    parameter int MOD_W  = 64,
    parameter int SIDE_W = 1
) (
    input  logic                 clk,
    input  logic                 s_rst_n,
    input  logic [2*MOD_W-1:0]   in_data,
    input  logic [SIDE_W-1:0]    in_side,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [MOD_W-1:0]     out_data,
    output logic [SIDE_W-1:0]    out_side,
    output logic                 out_vld,
    input  logic                 out_rdy
);

    localparam int H = MOD_W / 2;

`ifdef GOLDILOCKS_MOD_REDUCT_OUT_REG_EN
    localparam int NSTG = 4;
`else
    localparam int NSTG = 3;
`endif

    // 2^H - 1, the value 2^MOD_W folds to modulo p
    localparam logic [MOD_W-1:0] EPS = {{H{1'b0}}, {H{1'b1}}};
    // p = 2^MOD_W - 2^H + 1
    localparam logic [MOD_W-1:0] P   = {{H{1'b1}}, {(H-1){1'b0}}, 1'b1};

    // The whole pipeline moves together; it only freezes when a result is
    // waiting and the consumer is not taking it.
    logic en;
    assign en     = !(out_vld && !out_rdy);
    assign in_rdy = en;

    // ---------------- S1: t0 = x_lo - b, t1 = a*(2^H - 1) ----------------
    logic [MOD_W-1:0] x_lo;
    logic [H-1:0]     a_w;
    logic [H-1:0]     b_w;
    logic [MOD_W:0]   diff;
    logic [MOD_W-1:0] t0_next;
    logic [MOD_W-1:0] t1_next;

    assign x_lo = in_data[MOD_W-1:0];
    assign a_w  = in_data[MOD_W+H-1:MOD_W];
    assign b_w  = in_data[2*MOD_W-1:MOD_W+H];
    assign diff = {1'b0, x_lo} - {{(H+1){1'b0}}, b_w};

    // A borrow means the raw difference carries an extra +2^MOD_W, which is
    // congruent to 2^H - 1; removing it cannot underflow again because the
    // wrapped value is at least 2^MOD_W - 2^H + 1.
    assign t0_next = diff[MOD_W] ? (diff[MOD_W-1:0] - EPS) : diff[MOD_W-1:0];
    assign t1_next = {a_w, {H{1'b0}}} - {{H{1'b0}}, a_w};

    // ---------------- S2: r = t0 + t1 with carry folding ------------------
    logic [MOD_W-1:0] t0_reg;
    logic [MOD_W-1:0] t1_reg;
    logic [MOD_W:0]   sum;
    logic [MOD_W-1:0] r_next;

    assign sum = {1'b0, t0_reg} + {1'b0, t1_reg};
    // t1 <= (2^H-1)^2 bounds the wrapped sum so that adding 2^H - 1 back
    // never produces a second carry.
    assign r_next = sum[MOD_W] ? (sum[MOD_W-1:0] + EPS) : sum[MOD_W-1:0];

    // ---------------- S3: single conditional subtract ---------------------
    // r < 2^MOD_W < 2p, so one subtraction of p fully reduces it.
    logic [MOD_W-1:0] r_reg;
    logic [MOD_W-1:0] res_next;
    logic [MOD_W-1:0] res_reg;

    assign res_next = (r_reg >= P) ? (r_reg - P) : r_reg;

`ifdef GOLDILOCKS_MOD_REDUCT_OUT_REG_EN
    logic [MOD_W-1:0] out_reg;
`endif

    // Datapath registers carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (en) begin
            t0_reg  <= t0_next;
            t1_reg  <= t1_next;
            r_reg   <= r_next;
            res_reg <= res_next;
`ifdef GOLDILOCKS_MOD_REDUCT_OUT_REG_EN
            out_reg <= res_reg;
`endif
        end
    end

`ifdef GOLDILOCKS_MOD_REDUCT_OUT_REG_EN
    assign out_data = out_reg;
`else
    assign out_data = res_reg;
`endif

    // ---------------- valid / sideband shift chain ------------------------
    logic [NSTG:0]             vld_chain;
    logic [NSTG:0][SIDE_W-1:0] side_chain;

    assign vld_chain[0]  = in_vld;
    assign side_chain[0] = in_side;

    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_stage
            logic              vld_reg;
            logic [SIDE_W-1:0] side_reg;

            always_ff @(posedge clk or negedge s_rst_n) begin
                if (!s_rst_n) begin
                    vld_reg <= 1'b0;
                end else if (en) begin
                    vld_reg <= vld_chain[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    side_reg <= side_chain[gi];
                end
            end

            assign vld_chain[gi+1]  = vld_reg;
            assign side_chain[gi+1] = side_reg;
        end
    endgenerate

    assign out_vld  = vld_chain[NSTG];
    assign out_side = side_chain[NSTG];

endmodule

// File: tb/tb_goldilocks_mod_reduct.sv
// ---------------------------------------------------------------------------
// tb_goldilocks_mod_reduct
//
// Two instances (MOD_W = 64 and MOD_W = 32). Drivers push the expected
// result (x % p computed with plain wide arithmetic) into a queue when an
// operand is accepted; per-instance monitors pop and compare whenever a
// result is transferred.
// ---------------------------------------------------------------------------
module tb_goldilocks_mod_reduct;

`ifdef GOLDILOCKS_MOD_REDUCT_OUT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    localparam logic [63:0] P64 = 64'hFFFF_FFFF_0000_0001;
    localparam logic [31:0] P32 = 32'hFFFF_0001;

    logic clk = 1'b0;
    logic s_rst_n;
    always #5 clk = ~clk;

    logic [127:0] in_data_64;
    logic [7:0]   in_side_64;
    logic         in_vld_64, in_rdy_64, out_vld_64, out_rdy_64;
    logic [63:0]  out_data_64;
    logic [7:0]   out_side_64;

    logic [63:0]  in_data_32;
    logic [7:0]   in_side_32;
    logic         in_vld_32, in_rdy_32, out_vld_32, out_rdy_32;
    logic [31:0]  out_data_32;
    logic [7:0]   out_side_32;

    goldilocks_mod_reduct #(.MOD_W(64), .SIDE_W(8)) u_dut64 (
        .clk(clk), .s_rst_n(s_rst_n),
        .in_data(in_data_64), .in_side(in_side_64), .in_vld(in_vld_64), .in_rdy(in_rdy_64),
        .out_data(out_data_64), .out_side(out_side_64), .out_vld(out_vld_64), .out_rdy(out_rdy_64)
    );

    goldilocks_mod_reduct #(.MOD_W(32), .SIDE_W(8)) u_dut32 (
        .clk(clk), .s_rst_n(s_rst_n),
        .in_data(in_data_32), .in_side(in_side_32), .in_vld(in_vld_32), .in_rdy(in_rdy_32),
        .out_data(out_data_32), .out_side(out_side_32), .out_vld(out_vld_32), .out_rdy(out_rdy_32)
    );

    typedef struct packed { logic [63:0] data; logic [7:0] side; } exp64_t;
    typedef struct packed { logic [31:0] data; logic [7:0] side; } exp32_t;

    exp64_t q64[$];
    exp32_t q32[$];
    exp64_t e64;
    exp32_t e32;

    int n_cmp = 0;
    int n_bad = 0;
    bit done32 = 1'b0;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference model: straight modular arithmetic on the full operand.
    function automatic logic [63:0] ref64(input logic [127:0] x);
        logic [127:0] m;
        m = x % {64'd0, P64};
        return m[63:0];
    endfunction

    function automatic logic [31:0] ref32(input logic [63:0] x);
        logic [63:0] m;
        m = x % {32'd0, P32};
        return m[31:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (s_rst_n && out_vld_64 && out_rdy_64) begin
            if (q64.size() == 0) begin
                check(1'b0, "unexpected_out64", {56'd0, out_side_64, out_data_64}, 128'd0);
            end else begin
                e64 = q64.pop_front();
                $display("[%0t] out64 side=%02h data=%016h exp=%016h", $time,
                         out_side_64, out_data_64, e64.data);
                check(out_data_64 == e64.data, "data64", out_data_64, e64.data);
                check(out_side_64 == e64.side, "side64", out_side_64, e64.side);
                check(out_data_64 < P64, "range64", out_data_64, P64);
            end
        end
    end

    always @(negedge clk) begin
        if (s_rst_n && out_vld_32 && out_rdy_32) begin
            if (q32.size() == 0) begin
                check(1'b0, "unexpected_out32", {88'd0, out_side_32, out_data_32}, 128'd0);
            end else begin
                e32 = q32.pop_front();
                $display("[%0t] out32 side=%02h data=%08h exp=%08h", $time,
                         out_side_32, out_data_32, e32.data);
                check(out_data_32 == e32.data, "data32", out_data_32, e32.data);
                check(out_side_32 == e32.side, "side32", out_side_32, e32.side);
                check(out_data_32 < P32, "range32", out_data_32, P32);
            end
        end
    end

    // ---------------- drivers ----------------
    // Present x, wait for acceptance (sampled at negedge), then queue the
    // expectation. Returns at the negedge of the accepting cycle.
    task automatic send64(input logic [127:0] x, input logic [7:0] s,
                          input logic [63:0] e, output int waits);
        waits = 0;
        @(posedge clk); #1;
        in_data_64 = x; in_side_64 = s; in_vld_64 = 1'b1;
        @(negedge clk);
        while (!in_rdy_64 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_rdy_64) check(1'b0, "accept_timeout64", waits, 100);
        else q64.push_back('{data: e, side: s});
    endtask

    task automatic send32(input logic [63:0] x, input logic [7:0] s,
                          input logic [31:0] e, output int waits);
        waits = 0;
        @(posedge clk); #1;
        in_data_32 = x; in_side_32 = s; in_vld_32 = 1'b1;
        @(negedge clk);
        while (!in_rdy_32 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_rdy_32) check(1'b0, "accept_timeout32", waits, 100);
        else q32.push_back('{data: e, side: s});
    endtask

    task automatic idle64();
        @(posedge clk); #1;
        in_vld_64 = 1'b0;
    endtask

    task automatic idle32();
        @(posedge clk); #1;
        in_vld_32 = 1'b0;
    endtask

    task automatic drain64(input string name);
        int g = 0;
        while (q64.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check(q64.size() == 0, name, q64.size(), 0);
    endtask

    task automatic drain32(input string name);
        int g = 0;
        while (q32.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check(q32.size() == 0, name, q32.size(), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int lat;
        int g;
        logic [127:0] x;
        logic [63:0]  x32;
        logic [63:0]  hold_d;
        logic [7:0]   hold_s;

        s_rst_n    = 1'b0;
        in_data_64 = '0; in_side_64 = '0; in_vld_64 = 1'b0; out_rdy_64 = 1'b1;
        in_data_32 = '0; in_side_32 = '0; in_vld_32 = 1'b0; out_rdy_32 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check(out_vld_64 == 1'b0, "rst_out_vld64", out_vld_64, 0);
        check(in_rdy_64 == 1'b1, "rst_in_rdy64", in_rdy_64, 1);
        check(out_vld_32 == 1'b0, "rst_out_vld32", out_vld_32, 0);
        check(in_rdy_32 == 1'b1, "rst_in_rdy32", in_rdy_32, 1);
        @(posedge clk); #1;
        s_rst_n = 1'b1;

        // x = p reduces to zero; measure latency on an empty pipeline
        send64({64'd0, P64}, 8'h01, 64'd0, w);
        @(posedge clk); #1;
        in_vld_64 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_vld_64 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(lat == LAT, "latency64", lat, LAT);
        drain64("drain_p64");

        // x = 2^128 - 1: since 2^128 = -2^32 (mod p), result is p - 2^32 - 1
        send64({128{1'b1}}, 8'h02, 64'hFFFF_FFFE_0000_0000, w);
        idle64();
        drain64("drain_ones64");

        // Corner operands near p and 2^64 where the final subtract fires
        send64({64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 8'h03, ref64({64'd0, 64'hFFFF_FFFF_FFFF_FFFF}), w);
        send64({64'd0, P64 - 64'd1}, 8'h04, ref64({64'd0, P64 - 64'd1}), w);
        send64({64'd0, P64 + 64'd5}, 8'h05, ref64({64'd0, P64 + 64'd5}), w);
        send64({32'hFFFF_FFFF, 96'd0}, 8'h06, ref64({32'hFFFF_FFFF, 96'd0}), w);
        send64({32'd0, 32'hFFFF_FFFF, 64'd0}, 8'h07, ref64({32'd0, 32'hFFFF_FFFF, 64'd0}), w);
        idle64();
        drain64("drain_corner64");

        // 100 back-to-back random operands, consumer always ready
        for (int i = 0; i < 100; i++) begin
            x = rand128();
            send64(x, 8'(i), ref64(x), w);
            check(w == 0, "b2b_in_rdy64", w, 0);
        end
        idle64();
        drain64("drain_b2b64");

        // Consumer stalls 5 cycles while a result is held
        @(posedge clk); #1;
        out_rdy_64 = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    x = rand128();
                    send64(x, 8'hC0 + 8'(i), ref64(x), w);
                end
                idle64();
            end
            begin
                g = 0;
                @(negedge clk);
                while (!out_vld_64 && g < 50) begin
                    @(negedge clk);
                    g++;
                end
                check(out_vld_64 == 1'b1, "stall_vld_seen64", out_vld_64, 1);
                hold_d = out_data_64;
                hold_s = out_side_64;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check(in_rdy_64 == 1'b0, "stall_in_rdy64", in_rdy_64, 0);
                    check(out_vld_64 == 1'b1, "stall_out_vld64", out_vld_64, 1);
                    check(out_data_64 == hold_d, "stall_data_stable64", out_data_64, hold_d);
                    check(out_side_64 == hold_s, "stall_side_stable64", out_side_64, hold_s);
                end
                @(posedge clk); #1;
                out_rdy_64 = 1'b1;
            end
        join
        drain64("drain_stall64");

        // Reset with three operands in flight: none of them may ever appear
        for (int i = 0; i < 3; i++) begin
            x = rand128();
            send64(x, 8'hA0 + 8'(i), ref64(x), w);
        end
        @(posedge clk); #1;
        in_vld_64 = 1'b0;
        s_rst_n   = 1'b0;
        q64.delete();
        #1;
        check(out_vld_64 == 1'b0, "rst_async_vld64", out_vld_64, 0);
        check(in_rdy_64 == 1'b1, "rst_async_rdy64", in_rdy_64, 1);
        repeat (2) @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = rand128();
            send64(x, 8'hB0 + 8'(i), ref64(x), w);
        end
        idle64();
        drain64("drain_post_rst64");

        // MOD_W = 32: directed operand (a = 1, b = 0xFFFF -> 0xFFFF) with latency
        send32(64'hFFFF_0001_0000_FFFF, 8'h11, 32'h0000_FFFF, w);
        @(posedge clk); #1;
        in_vld_32 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_vld_32 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(lat == LAT, "latency32", lat, LAT);
        drain32("drain_dir32");

        // MOD_W = 32: 10000 random operands, random bubbles and back-pressure
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ((i % 64) == 0) x32 = {32'd0, P32 + 32'(i / 64)};
                    else x32 = {$urandom, $urandom};
                    send32(x32, 8'(i), ref32(x32), w);
                    if ($urandom_range(0, 7) == 0) idle32();
                end
                idle32();
                done32 = 1'b1;
            end
            begin
                while (!done32) begin
                    @(posedge clk); #1;
                    out_rdy_32 = ($urandom_range(0, 3) != 0);
                end
                out_rdy_32 = 1'b1;
            end
        join
        drain32("drain_rand32");

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
